// File: rtl/cast_scheduler.sv
// cast_scheduler: gathers one ifmap, filter and partial-sum operand, issues them
// to the MultiCaster as one pass, waits (bounded) for the returned psum and
// hands it to the buffer.
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   ifmap_/fltr_/psum_ valid,ready,data   operand handshakes (one slot each)
//   cfg_tag                        tag latched for the next pass
//   caster_en                      {psum,fltr,ifmap} enable, one cycle per pass
//   bus_tag, ifmap_bus, fltr_bus, psum_bus   pass tag and slot contents
//   caster_ready, caster_valid, result_data  caster side handshake / result
//   out_valid, out_ready, out_data result handshake to the buffer
//   pass_cnt                       completed passes, 8-bit wrap
//   err_timeout                    one-cycle pulse on a WAIT abort
module cast_scheduler #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      ifmap_valid,
  output logic                      ifmap_ready,
  input  logic [DATA_WIDTH-1:0]     ifmap_data,
  input  logic                      fltr_valid,
  output logic                      fltr_ready,
  input  logic [DATA_WIDTH-1:0]     fltr_data,
  input  logic                      psum_valid,
  output logic                      psum_ready,
  input  logic [2*DATA_WIDTH-1:0]   psum_data,
  input  logic [TAG_WIDTH-1:0]      cfg_tag,
  output logic [2:0]                caster_en,
  output logic [TAG_WIDTH-1:0]      bus_tag,
  output logic [DATA_WIDTH-1:0]     ifmap_bus,
  output logic [DATA_WIDTH-1:0]     fltr_bus,
  output logic [2*DATA_WIDTH-1:0]   psum_bus,
  input  logic                      caster_ready,
  input  logic                      caster_valid,
  input  logic [2*DATA_WIDTH-1:0]   result_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   out_data,
  output logic [7:0]                pass_cnt,
  output logic                      err_timeout
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  state_t        state;
  logic          ifmap_full;
  logic          fltr_full;
  logic          psum_full;
  logic [CW-1:0] tcnt;
  logic          in_collect;
  logic          timeout_hit;

  assign in_collect  = (state == ST_COLLECT);
  assign timeout_hit = (tcnt == CW'(TIMEOUT - 1));

  // Slot acceptance; rstn gating keeps readys low during reset regardless of state.
  assign ifmap_ready = in_collect & ~ifmap_full & rstn;
  assign fltr_ready  = in_collect & ~fltr_full  & rstn;
  assign psum_ready  = in_collect & ~psum_full  & rstn;

  // Enable fires in the same cycle the caster reports ready; that cycle also
  // moves the FSM to WAIT, so it is high exactly once per pass.
  assign caster_en = (rstn && (state == ST_ISSUE) && caster_ready) ? 3'b111 : 3'b000;

  // Pass sequencer: slots, flags, tag, timeout counter and result register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_COLLECT;
      ifmap_full  <= 1'b0;
      fltr_full   <= 1'b0;
      psum_full   <= 1'b0;
      ifmap_bus   <= '0;
      fltr_bus    <= '0;
      psum_bus    <= '0;
      bus_tag     <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      pass_cnt    <= '0;
      err_timeout <= 1'b0;
      tcnt        <= '0;
    end else begin
      err_timeout <= 1'b0;
      case (state)
        ST_COLLECT: begin
          if (ifmap_valid && ifmap_ready) begin
            ifmap_bus  <= ifmap_data;
            ifmap_full <= 1'b1;
          end
          if (fltr_valid && fltr_ready) begin
            fltr_bus  <= fltr_data;
            fltr_full <= 1'b1;
          end
          if (psum_valid && psum_ready) begin
            psum_bus  <= psum_data;
            psum_full <= 1'b1;
          end
          // Flags are registered, so the pass starts one edge after the last accept.
          if (ifmap_full && fltr_full && psum_full) begin
            bus_tag <= cfg_tag;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (caster_ready) begin
            tcnt  <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A result arriving on the last allowed cycle still counts.
          if (caster_valid) begin
            out_data  <= result_data;
            out_valid <= 1'b1;
            state     <= ST_DRAIN;
          end else if (timeout_hit) begin
            err_timeout <= 1'b1;
            ifmap_full  <= 1'b0;
            fltr_full   <= 1'b0;
            psum_full   <= 1'b0;
            state       <= ST_COLLECT;
          end else begin
            tcnt <= tcnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            ifmap_full <= 1'b0;
            fltr_full  <= 1'b0;
            psum_full  <= 1'b0;
            pass_cnt   <= pass_cnt + 8'd1;
            state      <= ST_COLLECT;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule
